jt8255_peer: RTL and testbench

//  Peripheral-side peer for the jt8255 strobed handshake ports (mode 1/2, port A or B).
//  TX path feeds bytes into an 8255 input port: drives data, pulses STB#, waits for the IBF cycle.
//  RX path drains an 8255 output port: samples data on OBF#, pulses ACK#, waits for OBF# release.

---
 rtl/jt8255_pkg.sv | 40 ++++
 rtl/jt8255_peer_if.sv | 25 ++
 rtl/jt8255_peer_fifo.sv | 57 +++++
 rtl/jt8255_peer.sv | 159 +++++++++++++++
 tb/tb_jt8255_peer.sv | 264 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/jt8255_pkg.sv
`default_nettype none
// ============================================================================
// Module   : jt8255_pkg
// Brief    : Shared encodings for the jt8255 PPI and its peripheral-side peer.
// Revision : 1.0 - initial release
// ============================================================================
package jt8255_pkg;

    typedef enum logic [2:0] {
        TX_IDLE    = 3'd0,
        TX_SETUP   = 3'd1,
        TX_STROBE  = 3'd2,
        TX_WAIT_HI = 3'd3,
        TX_WAIT_LO = 3'd4
    } tx_state_t;

    typedef enum logic [1:0] {
        RX_IDLE    = 2'd0,
        RX_ACK     = 2'd1,
        RX_RELEASE = 2'd2
    } rx_state_t;

    // Port C bit positions of the mode 1/2 handshake lines
    localparam int PC_STBA = 4;
    localparam int PC_IBFA = 5;
    localparam int PC_ACKA = 6;
    localparam int PC_OBFA = 7;
    localparam int PC_STBB = 2;
    localparam int PC_ACKB = 2;
    localparam int PC_IBFB = 1;
    localparam int PC_OBFB = 1;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage
`default_nettype wire

// File: rtl/jt8255_peer_if.sv
`default_nettype none
// ============================================================================
// Module   : jt8255_peer_if
// Brief    : Pin-level strobed handshake bundle between an 8255 port and a peer.
// Revision : 1.0 - initial release
// ============================================================================
interface jt8255_peer_if;
    logic [7:0] pio_din;
    logic [7:0] pio_dout;
    logic       stb_n;
    logic       ibf;
    logic       obf_n;
    logic       ack_n;

    modport master (
        input  pio_din, ibf, obf_n,
        output pio_dout, stb_n, ack_n
    );

    modport slave (
        input  pio_dout, stb_n, ack_n,
        output pio_din, ibf, obf_n
    );
endinterface
`default_nettype wire

// File: rtl/jt8255_peer_fifo.sv
`default_nettype none
// ============================================================================
// Module   : jt8255_peer_fifo
// Brief    : Small synchronous RX FIFO, built only with JT8255_PEER_FIFO_EN.
// Revision : 1.0 - initial release
// ============================================================================
`ifdef JT8255_PEER_FIFO_EN
module jt8255_peer_fifo #(
    parameter int AW = 2,
    parameter int W  = 8
) (
    input  wire logic          clk,
    input  wire logic          rst,
    input  wire logic          push,
    input  wire logic [W-1:0]  din,
    input  wire logic          pop,
    output logic      [W-1:0]  dout,
    output logic               full,
    output logic               empty,
    output logic      [AW:0]   count
);
    localparam int DEPTH = 1 << AW;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule
`endif
`default_nettype wire

// File: rtl/jt8255_peer.sv
`default_nettype none
// ============================================================================
// Module   : jt8255_peer
// Brief    : Peripheral-side peer for jt8255 mode 1/2 strobed ports (TX + RX).
//            Define JT8255_PEER_FIFO_EN for a 2**FIFO_AW deep RX FIFO.
// Revision : 1.0 - initial release
// ============================================================================
module jt8255_peer
    import jt8255_pkg::*;
#(
    parameter int SETUP   = 2,
    parameter int STB_W   = 4,
    parameter int ACK_W   = 4,
    parameter int FIFO_AW = 2
) (
    input  wire logic       clk,
    input  wire logic       rst,
    input  wire logic [7:0] tx_data,
    input  wire logic       tx_valid,
    output logic            tx_ready,
    output logic      [7:0] rx_data,
    output logic            rx_valid,
    input  wire logic       rx_ready,
    jt8255_peer_if.master   pio
);
    localparam int CW = $clog2(max3(SETUP, STB_W, ACK_W)) + 1;

    if (SETUP < 1 || STB_W < 2 || ACK_W < 2 || FIFO_AW < 1) begin : g_bad_param
        $error("jt8255_peer: parameter out of range");
    end

    tx_state_t     tx_state;
    rx_state_t     rx_state;
    logic [CW-1:0] tx_cnt;
    logic [CW-1:0] rx_cnt;
    logic          stb_n;
    logic          ack_n;
    logic [7:0]    pio_dout;
    logic          rx_push;
    logic          rx_pop;
    logic          rx_full;

    assign pio.stb_n    = stb_n;
    assign pio.ack_n    = ack_n;
    assign pio.pio_dout = pio_dout;

    assign tx_ready = (tx_state == TX_IDLE) && !pio.ibf;
    assign rx_push  = (rx_state == RX_IDLE) && !pio.obf_n && !rx_full;
    assign rx_pop   = rx_valid && rx_ready;

    // pio_dout stays on the pins through WAIT_LO because the 8255 reads them live
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_state <= TX_IDLE;
            tx_cnt   <= '0;
            stb_n    <= 1'b1;
            pio_dout <= 8'hff;
        end else begin
            case (tx_state)
                TX_IDLE: begin
                    if (tx_valid && !pio.ibf) begin
                        pio_dout <= tx_data;
                        tx_cnt   <= CW'(SETUP - 1);
                        tx_state <= TX_SETUP;
                    end
                end
                TX_SETUP: begin
                    if (tx_cnt == '0) begin
                        stb_n    <= 1'b0;
                        tx_cnt   <= CW'(STB_W - 1);
                        tx_state <= TX_STROBE;
                    end else begin
                        tx_cnt <= tx_cnt - 1'b1;
                    end
                end
                TX_STROBE: begin
                    if (tx_cnt == '0) begin
                        stb_n    <= 1'b1;
                        tx_state <= TX_WAIT_HI;
                    end else begin
                        tx_cnt <= tx_cnt - 1'b1;
                    end
                end
                TX_WAIT_HI: if (pio.ibf)  tx_state <= TX_WAIT_LO;
                TX_WAIT_LO: if (!pio.ibf) tx_state <= TX_IDLE;
                default:    tx_state <= TX_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_state <= RX_IDLE;
            rx_cnt   <= '0;
            ack_n    <= 1'b1;
        end else begin
            case (rx_state)
                RX_IDLE: begin
                    if (rx_push) begin
                        ack_n    <= 1'b0;
                        rx_cnt   <= CW'(ACK_W - 1);
                        rx_state <= RX_ACK;
                    end
                end
                RX_ACK: begin
                    if (rx_cnt == '0) begin
                        ack_n    <= 1'b1;
                        rx_state <= RX_RELEASE;
                    end else begin
                        rx_cnt <= rx_cnt - 1'b1;
                    end
                end
                RX_RELEASE: if (pio.obf_n) rx_state <= RX_IDLE;
                default:    rx_state <= RX_IDLE;
            endcase
        end
    end

`ifdef JT8255_PEER_FIFO_EN
    logic             fifo_full;
    logic             fifo_empty;
    logic [FIFO_AW:0] fifo_count;

    jt8255_peer_fifo #(
        .AW (FIFO_AW),
        .W  (8)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (rx_push),
        .din   (pio.pio_din),
        .pop   (rx_pop),
        .dout  (rx_data),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign rx_full  = fifo_full;
    assign rx_valid = !fifo_empty;
`else
    // Single holding register: a byte waiting here blocks the next ACK#
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_data  <= 8'h00;
            rx_valid <= 1'b0;
        end else if (rx_push) begin
            rx_data  <= pio.pio_din;
            rx_valid <= 1'b1;
        end else if (rx_pop) begin
            rx_valid <= 1'b0;
        end
    end

    assign rx_full = rx_valid;
`endif

endmodule
`default_nettype wire

// File: tb/tb_jt8255_peer.sv
`default_nettype none
// ============================================================================
// Module   : tb_jt8255_peer
// Brief    : Directed bench: jt8255_peer against a behavioural 8255 port model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_jt8255_peer;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    jt8255_peer_if pio();

    jt8255_peer #(
        .SETUP   (2),
        .STB_W   (4),
        .ACK_W   (4),
        .FIFO_AW (2)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_ready (rx_ready),
        .pio      (pio)
    );

    // 8255 model: port A input with IBF, port B output with OBF#
    logic       ibf_m, obf_n_m, stb_prev, ack_prev;
    logic       force_ibf, rd_req, wr_req;
    logic [7:0] porta_m, portb_m, wr_data;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            ibf_m    <= 1'b0;
            obf_n_m  <= 1'b1;
            stb_prev <= 1'b1;
            ack_prev <= 1'b1;
            porta_m  <= 8'h00;
            portb_m  <= 8'h00;
        end else begin
            stb_prev <= pio.stb_n;
            ack_prev <= pio.ack_n;
            if (!pio.stb_n) porta_m <= pio.pio_dout;
            if (pio.stb_n && !stb_prev) ibf_m <= 1'b1;
            else if (rd_req)            ibf_m <= 1'b0;
            if (wr_req) begin
                portb_m <= wr_data;
                obf_n_m <= 1'b0;
            end else if (pio.ack_n && !ack_prev) begin
                obf_n_m <= 1'b1;
            end
        end
    end

    assign pio.ibf     = ibf_m | force_ibf;
    assign pio.obf_n   = obf_n_m;
    assign pio.pio_din = portb_m;

    localparam int S_IBF = 0, S_OBF = 1, S_RXV = 2, S_STB = 3, S_TXR = 4;

    function automatic logic sig(input int w);
        case (w)
            S_IBF:   return pio.ibf;
            S_OBF:   return pio.obf_n;
            S_RXV:   return rx_valid;
            S_STB:   return pio.stb_n;
            S_TXR:   return tx_ready;
            default: return 1'bx;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_for(input int w, input logic lvl, input string tag);
        int i;
        i = 0;
        while (sig(w) !== lvl && i < 200) begin
            @(negedge clk);
            i++;
        end
        chk(tag, 32'(sig(w)), 32'(lvl));
    endtask

    task automatic cpu_write(input logic [7:0] d);
        wr_data = d;
        wr_req  = 1'b1;
        @(negedge clk);
        wr_req  = 1'b0;
    endtask

    task automatic cpu_read(output logic [7:0] d);
        d      = porta_m;
        rd_req = 1'b1;
        @(negedge clk);
        rd_req = 1'b0;
    endtask

    initial begin
        logic [7:0] d;
        int         n, bad, acked, stop_k, exp_acked;
        logic [7:0] q[$];

        rst = 1'b1; tx_data = 8'h00; tx_valid = 1'b0; rx_ready = 1'b0;
        force_ibf = 1'b0; rd_req = 1'b0; wr_req = 1'b0; wr_data = 8'h00;
        repeat (3) @(negedge clk);
        chk("rst_stb_n",    32'(pio.stb_n),  32'h1);
        chk("rst_ack_n",    32'(pio.ack_n),  32'h1);
        chk("rst_pio_dout", 32'(pio.pio_dout), 32'hff);
        chk("rst_rx_valid", 32'(rx_valid),   32'h0);
        chk("rst_rx_data",  32'(rx_data),    32'h00);
        chk("rst_tx_ready", 32'(tx_ready),   32'h1);
        rst = 1'b0;
        @(negedge clk);

        // TX 8'h5a: 2 setup cycles, 4 strobe cycles, IBF cycle
        tx_data = 8'h5a; tx_valid = 1'b1;
        chk("tx_ready_idle", 32'(tx_ready), 32'h1);
        @(negedge clk);
        tx_valid = 1'b0;
        n = 0;
        while (pio.stb_n && n < 20) begin n++; @(negedge clk); end
        chk("setup_cycles", 32'(n), 32'd2);
        chk("tx_pio_dout", 32'(pio.pio_dout), 32'h5a);
        n = 0;
        while (!pio.stb_n && n < 20) begin n++; @(negedge clk); end
        chk("stb_width", 32'(n), 32'd4);
        wait_for(S_IBF, 1'b1, "ibf_set");
        chk("tx_ready_ibf", 32'(tx_ready), 32'h0);
        cpu_read(d);
        chk("porta_read_5a", 32'(d), 32'h5a);
        wait_for(S_IBF, 1'b0, "ibf_clear");
        wait_for(S_TXR, 1'b1, "tx_ready_back");

        // tx_valid while IBF is held high
        force_ibf = 1'b1;
        @(negedge clk);
        tx_data = 8'h77; tx_valid = 1'b1;
        bad = 0;
        repeat (10) begin
            @(negedge clk);
            if (pio.stb_n !== 1'b1 || tx_ready !== 1'b0) bad++;
        end
        chk("ibf_blocks_tx", 32'(bad), 32'd0);
        chk("pio_dout_retained", 32'(pio.pio_dout), 32'h5a);
        force_ibf = 1'b0;
        #1;
        chk("tx_ready_release", 32'(tx_ready), 32'h1);
        @(negedge clk);
        tx_valid = 1'b0;
        chk("tx_start_next", 32'(pio.pio_dout), 32'h77);
        wait_for(S_STB, 1'b0, "stb_low_77");
        wait_for(S_STB, 1'b1, "stb_high_77");
        wait_for(S_IBF, 1'b1, "ibf_set_77");
        cpu_read(d);
        chk("porta_read_77", 32'(d), 32'h77);
        wait_for(S_TXR, 1'b1, "tx_ready_77");

        // RX 8'hc3
        cpu_write(8'hc3);
        chk("obf_low", 32'(pio.obf_n), 32'h0);
        wait_for(S_RXV, 1'b1, "rx_valid_c3");
        chk("rx_data_c3", 32'(rx_data), 32'hc3);
        n = 0;
        while (!pio.ack_n && n < 20) begin n++; @(negedge clk); end
        chk("ack_width", 32'(n), 32'd4);
        wait_for(S_OBF, 1'b1, "obf_release");
        chk("rx_data_hold", 32'(rx_data), 32'hc3);
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
        chk("rx_pop", 32'(rx_valid), 32'h0);

        // Backpressure: consumer stalled, CPU writes 1..5
`ifdef JT8255_PEER_FIFO_EN
        exp_acked = 4;
`else
        exp_acked = 1;
`endif
        acked = 0; stop_k = 0;
        for (int k = 1; k <= 5 && stop_k == 0; k++) begin
            cpu_write(8'(k));
            n = 0;
            while (pio.obf_n === 1'b0 && n < 30) begin n++; @(negedge clk); end
            if (pio.obf_n === 1'b1) acked++;
            else stop_k = k;
        end
        chk("bp_acked", 32'(acked), 32'(exp_acked));
        chk("bp_obf_held", 32'(pio.obf_n), 32'h0);
        chk("bp_ack_high", 32'(pio.ack_n), 32'h1);
        chk("bp_rx_data", 32'(rx_data), 32'h01);
        rx_ready = 1'b1;
        repeat (40) begin
            if (rx_valid) q.push_back(rx_data);
            @(negedge clk);
        end
        rx_ready = 1'b0;
        chk("drain_count", 32'(q.size()), 32'(exp_acked + 1));
        for (int i = 0; i < q.size(); i++) chk("drain_order", 32'(q[i]), 32'(i + 1));
        wait_for(S_OBF, 1'b1, "bp_obf_release");

        // Reset in the middle of a strobe
        cpu_write(8'h44);
        wait_for(S_RXV, 1'b1, "pre_rst_rx_valid");
        wait_for(S_OBF, 1'b1, "pre_rst_obf");
        tx_data = 8'h99; tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        wait_for(S_STB, 1'b0, "strobe_entered");
        #2 rst = 1'b1;
        #1;
        chk("rst_mid_stb_n",    32'(pio.stb_n),    32'h1);
        chk("rst_mid_pio_dout", 32'(pio.pio_dout), 32'hff);
        chk("rst_mid_rx_valid", 32'(rx_valid),     32'h0);
        @(negedge clk);
        rst = 1'b0;
        chk("rst_mid_tx_ready", 32'(tx_ready), 32'h1);
        bad = 0;
        repeat (10) begin
            @(negedge clk);
            if (pio.stb_n !== 1'b1 || pio.ack_n !== 1'b1) bad++;
        end
        chk("rst_byte_dropped", 32'(bad), 32'd0);

        // Simultaneous TX 8'h11 and RX 8'h22 (mode 2 port A)
        tx_data = 8'h11; tx_valid = 1'b1;
        wr_data = 8'h22; wr_req = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0; wr_req = 1'b0;
        wait_for(S_RXV, 1'b1, "m2_rx_valid");
        chk("m2_rx_data", 32'(rx_data), 32'h22);
        wait_for(S_IBF, 1'b1, "m2_ibf");
        cpu_read(d);
        chk("m2_porta_read", 32'(d), 32'h11);
        wait_for(S_TXR, 1'b1, "m2_tx_ready");
        wait_for(S_OBF, 1'b1, "m2_obf_release");
        chk("m2_rx_data_hold", 32'(rx_data), 32'h22);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
